// File: rtl/sound_pkg.sv
// Shared constants and types for the M68K-to-Z80 sound mailbox.
package sound_pkg;

    localparam int          BANK_W          = 5;
    localparam int          LATCH_W         = 8;
    localparam logic [15:0] IRQ_DIV_DEFAULT = 16'd3200;

    // HELD blocks capture until the M68K select has been seen low again.
    typedef enum logic {
        WR_ARMED = 1'b0,
        WR_HELD  = 1'b1
    } wr_arm_e;

    function automatic logic [BANK_W-1:0] bank_field(input logic [LATCH_W-1:0] data);
        return data[BANK_W-1:0];
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered 1-bit rising-edge detector; the pulse is high on the first cycle the input is seen high.
module edge_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/sound_mailbox.sv
// M68K -> Z80 sound command latch with pending/overrun flags, Z80 ROM bank register and periodic IRQ timer.
module sound_mailbox
    import sound_pkg::*;
#(
    parameter logic [15:0] IRQ_DIV      = 16'd3200,
    parameter logic        NMI_ON_WRITE = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               m68k_latch_cs,
    input  logic               m68k_lds_n,
    input  logic [LATCH_W-1:0] m68k_dout,
    input  logic               z80_latch_cs,
    input  logic               z80_latch_clr_cs,
    input  logic               z80_bank_set_cs,
    input  logic [LATCH_W-1:0] z80_dout,
    input  logic               z80_m1_n,
    input  logic               z80_iorq_n,
    output logic [LATCH_W-1:0] z80_latch_dout,
    output logic [BANK_W-1:0]  z80_bank,
    output logic               z80_nmi_n,
    output logic               z80_irq_n,
    output logic               latch_pending,
    output logic               latch_overrun
);

    wr_arm_e            wr_arm_q, wr_arm_d;
    logic [LATCH_W-1:0] latch_q, latch_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               irq_req_q, irq_req_d;
    logic               capture_s, clr_rise_s, bank_rise_s, wrap_s, ack_s;

    // Z80 reads are pure data-bus reads and need no state here.
    logic unused_s;
    assign unused_s = &{1'b0, z80_latch_cs};

    edge_rise u_clr_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (z80_latch_clr_cs),
        .rise_o  (clr_rise_s)
    );

    edge_rise u_bank_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (z80_bank_set_cs),
        .rise_o  (bank_rise_s)
    );

    // Write arming: one capture per select assertion.
    always_comb begin
        wr_arm_d  = wr_arm_q;
        capture_s = 1'b0;
        case (wr_arm_q)
            WR_ARMED: begin
                if (m68k_latch_cs && !m68k_lds_n) begin
                    capture_s = 1'b1;
                    wr_arm_d  = WR_HELD;
                end else begin
                    wr_arm_d  = WR_ARMED;
                end
            end
            WR_HELD: begin
                if (!m68k_latch_cs) begin
                    wr_arm_d = WR_ARMED;
                end else begin
                    wr_arm_d = WR_HELD;
                end
            end
            default: wr_arm_d = WR_HELD;
        endcase
    end

    // Latch, flags and bank next state; a capture beats a simultaneous clear.
    always_comb begin
        latch_d   = latch_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        bank_d    = bank_q;
        if (capture_s) begin
            latch_d   = m68k_dout;
            pending_d = 1'b1;
            overrun_d = overrun_q | pending_q;
        end else if (clr_rise_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (bank_rise_s) begin
            bank_d = bank_field(z80_dout);
        end else begin
            bank_d = bank_q;
        end
    end

    // Free-running IRQ divider; a wrap beats a coincident acknowledge.
    always_comb begin
        ack_s     = !z80_m1_n && !z80_iorq_n;
        wrap_s    = (cnt_q == (IRQ_DIV - 16'd1));
        cnt_d     = cnt_q + 16'd1;
        irq_req_d = irq_req_q;
        if (wrap_s) begin
            cnt_d     = 16'd0;
            irq_req_d = 1'b1;
        end else if (ack_s) begin
            irq_req_d = 1'b0;
        end else begin
            irq_req_d = irq_req_q;
        end
    end

    // State registers; wr_arm comes out of reset blocked so a held select is not captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_arm_q  <= WR_HELD;
            latch_q   <= 8'h00;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            bank_q    <= 5'd0;
            cnt_q     <= 16'd0;
            irq_req_q <= 1'b0;
        end else begin
            wr_arm_q  <= wr_arm_d;
            latch_q   <= latch_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            bank_q    <= bank_d;
            cnt_q     <= cnt_d;
            irq_req_q <= irq_req_d;
        end
    end

    assign z80_latch_dout = latch_q;
    assign z80_bank       = bank_q;
    assign latch_pending  = pending_q;
    assign latch_overrun  = overrun_q;
    assign z80_nmi_n      = !(pending_q && NMI_ON_WRITE);
    assign z80_irq_n      = !irq_req_q;

endmodule
